// File: rtl/imem_load_arbiter.sv
// ----------------------------------------------------------------------------
// imem_load_arbiter
//
// Shares one single-port synchronous instruction RAM between the CPU fetch
// path (read-only) and a program-loader port (burst writes), so programs can
// be loaded at run time. While a load session is open the CPU is stalled.
//
// Ports
//   Clk, Rst      rising-edge clock, synchronous active-high reset
//   fetch_req     CPU wants the instruction at fetch_addr (byte address)
//   fetch_addr    byte address; word index = fetch_addr[ADDR_W+1:2]
//   fetch_valid   fetch_instr holds the word for the fetch accepted last cycle
//   fetch_instr   fetched instruction (holds its last value when not valid)
//   fetch_stall   fetch_req is not being accepted this cycle
//   load_start    one-cycle pulse opening a load session
//   load_base     first word index written (sampled with load_start)
//   load_len      number of words in the session (sampled with load_start)
//   load_wvalid   load_wdata is valid
//   load_wdata    instruction word to write
//   load_wready   a presented word is accepted this cycle
//   load_done     one-cycle pulse closing the session
//   mem_addr      RAM word index
//   mem_we        RAM write enable
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data, registered, one-cycle latency
//   dbg_state     current FSM state (0 RUN, 1 LOAD, 2 DONE)
//
// Handshake: a loader word transfers in every cycle where load_wvalid and
// load_wready are both high; load_wvalid may drop at any time and the session
// simply waits. A fetch transfers in every cycle where fetch_req is high and
// fetch_stall is low; its data appears exactly one cycle later.
// ----------------------------------------------------------------------------
module imem_load_arbiter #(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_stall,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              load_wvalid,
    input  logic [31:0]       load_wdata,
    output logic              load_wready,
    output logic              load_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   base_q;
    logic                fetch_pend_q;   // a fetch was accepted last cycle
    logic [31:0]         instr_hold_q;   // last delivered instruction
    logic                fetch_accept;
    logic [ADDR_W-1:0]   fetch_idx;
    logic [ADDR_W-1:0]   load_ptr;

    // Byte-offset and high address bits play no part in word selection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    assign fetch_idx = fetch_addr[ADDR_W+1:2];
    // Natural ADDR_W-bit overflow gives the wrap past the top word.
    assign load_ptr  = base_q + ADDR_W'(cnt_q);

    // The RAM read is registered, so the word for a fetch accepted last cycle
    // is on mem_rdata now; otherwise show the last delivered word.
    assign fetch_valid = fetch_pend_q;
    assign fetch_instr = fetch_pend_q ? mem_rdata : instr_hold_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_stall  = 1'b0;
        fetch_accept = 1'b0;
        load_wready  = 1'b0;
        load_done    = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        case (state_q)
            ST_RUN: begin
                fetch_stall  = load_start;
                mem_addr     = fetch_idx;
                // A load request wins over a same-cycle fetch.
                fetch_accept = fetch_req && !load_start;
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                fetch_stall = 1'b1;
                mem_addr    = load_ptr;
                if (len_q == '0) begin
                    // Empty session: pass straight through with no writes.
                    state_d = ST_DONE;
                end else begin
                    load_wready = 1'b1;
                    if (load_wvalid) begin
                        mem_we    = 1'b1;
                        mem_wdata = load_wdata;
                        cnt_d     = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                fetch_stall = 1'b1;
                load_done   = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            len_q        <= '0;
            base_q       <= '0;
            fetch_pend_q <= 1'b0;
            instr_hold_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fetch_pend_q <= fetch_accept;
            if (fetch_pend_q) begin
                instr_hold_q <= mem_rdata;
            end
            if (state_q == ST_RUN && load_start) begin
                base_q <= load_base;
                len_q  <= load_len;
            end
        end
    end

endmodule
